pc_next_unit: RTL
=================

// Module: pc_next_unit
// PURPOSE
//  Program-counter stage downstream of the branch-offset left shifter. Holds the PC
//  register and forms PC+4 and branch target = PC + ls_i (ls_i = shifted sign-extended imm).
//  Selects the next PC from jump/branch/zero and stalls the PC under a hold request.
//  Keeps redirects issued while stalled, traps misaligned targets, counts taken redirects.
// PARAMETERS
//  WORD      32            datapath / address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  TRAP_VEC  32'h0000_0100 PC loaded when a taken target is misaligned
//  CNT_W     16            width of taken-redirect counter
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  stall_i        in   1       1 = hold PC this cycle
//  branch_i       in   1       conditional branch instruction
//  zero_i         in   1       ALU zero flag (branch condition)
//  jump_i         in   1       unconditional jump
//  ls_i           in   WORD    shifted offset from shift-left stage
//  pc_o           out  WORD    current PC (register output)
//  pc_plus4_o     out  WORD    pc_o + 4, combinational
//  target_o       out  WORD    pc_o + ls_i, combinational, modulo 2^WORD
//  taken_o        out  1       combinational: jump_i | (branch_i & zero_i)
//  pending_o      out  1       registered: redirect captured during stall, not yet applied
//  misalign_o     out  1       registered one-cycle pulse: trap taken on misaligned target
//  redirect_cnt_o out  CNT_W   registered count of applied redirects, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): pc_o=RESET_PC, pending_o=0, misalign_o=0, redirect_cnt_o=0.
//    Pending target register cleared. Reset mid-stall discards any pending redirect.
//  - Adds wrap modulo 2^WORD with no carry-out. ls_i is used as-is and is not re-shifted.
//  - Misaligned means target[1:0] != 2'b00. This is evaluated only when a redirect is applied.
//  - States: RUN (pending_o=0), HOLD (pending_o=1). Next-PC rules, per rising edge:
//    RUN,  stall_i=0, taken_o=0: pc <= pc+4.
//    RUN,  stall_i=0, taken_o=1: apply target_o (see apply rule).
//    RUN,  stall_i=1, taken_o=0: pc holds.
//    RUN,  stall_i=1, taken_o=1: pc holds; latch target_o; go to HOLD.
//    HOLD, stall_i=1: pc holds; the latched target is kept.
//      New taken_o is ignored because the stalled instruction is the same one.
//    HOLD, stall_i=0: apply the latched target, not the live inputs; go to RUN.
//  - Apply rule for target T:
//    if T[1:0]==0: pc <= T.
//    else: pc <= TRAP_VEC and misalign_o=1 for exactly that one cycle.
//    In both cases redirect_cnt_o increments, holding at all-ones.
//  - misalign_o is 0 on every cycle that does not apply a misaligned redirect.
//  - Latency: the next PC is visible on pc_o one cycle after the deciding edge.
//    A redirect captured in HOLD becomes visible one cycle after stall_i deasserts.
//  - pc_plus4_o, target_o and taken_o are valid whenever the inputs are stable. No X on outputs after reset.
// TESTING
//  1. Reset, RESET_PC=0; stall=0, no branch, 4 clocks -> pc_o 0,4,8,12,16; cnt=0.
//  2. pc=0x10, branch=1, zero=1, ls=0x20 -> next pc_o=0x30, cnt=1.
//     Same with zero=0 -> pc_o=0x14.
//  3. pc=0x40, stall=1, jump=1, ls=0x08 -> pc holds at 0x40, pending_o=1.
//     Hold 3 cycles while ls changes to 0x100. Release stall -> pc_o=0x48, pending_o=0.
//  4. pc=0x20, jump=1, ls=0x06 -> pc_o=TRAP_VEC=0x100, misalign_o=1 for 1 cycle, cnt increments.
//  5. pc=0xFFFF_FFFC with no branch -> pc_o=0x0. With jump and ls=0x8 -> target_o=0x4 (wrap).
//  6. Preload cnt to 0xFFFE; apply 3 jumps -> cnt 0xFFFF, saturated.
//     Assert rst mid-HOLD -> pc_o=RESET_PC immediately, pending_o=0, cnt=0.

Source files
------------

// File: rtl/pc_next_if.sv
// Interface for the PC next-address stage.
// The slave side is the PC unit. The master side drives the branch and stall controls.
interface pc_next_if #(
  parameter int WORD  = 32,
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             branch_i;
  logic             zero_i;
  logic             jump_i;
  logic [WORD-1:0]  ls_i;
  logic [WORD-1:0]  pc_o;
  logic [WORD-1:0]  pc_plus4_o;
  logic [WORD-1:0]  target_o;
  logic             taken_o;
  logic             pending_o;
  logic             misalign_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  modport master (
    output stall_i, branch_i, zero_i, jump_i, ls_i,
    input  pc_o, pc_plus4_o, target_o, taken_o, pending_o, misalign_o, redirect_cnt_o
  );

  modport slave (
    input  stall_i, branch_i, zero_i, jump_i, ls_i,
    output pc_o, pc_plus4_o, target_o, taken_o, pending_o, misalign_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_next_unit.sv
// PC register with PC+4 and branch-target adders, and stall handling.
// A redirect raised during a stall is held until the stall is released; misaligned targets go to a trap.
module pc_next_unit #(
  parameter int              WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int              CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  pc_next_if.slave    bus
);
  typedef enum logic {RUN, HOLD} state_t;

  state_t           st;
  logic [WORD-1:0]  pc_q, pend_q, apply_tgt;
  logic [CNT_W-1:0] cnt_q;
  logic             mis_q, apply_en;

  assign bus.pc_o           = pc_q;
  assign bus.pc_plus4_o     = pc_q + WORD'(4);
  assign bus.target_o       = pc_q + bus.ls_i;
  assign bus.taken_o        = bus.jump_i | (bus.branch_i & bus.zero_i);
  assign bus.pending_o      = (st == HOLD);
  assign bus.misalign_o     = mis_q;
  assign bus.redirect_cnt_o = cnt_q;

  // On release from HOLD, use the latched target. The live inputs still describe the same stalled instruction.
  always_comb begin
    apply_en  = 1'b0;
    apply_tgt = bus.target_o;
    if (!bus.stall_i) begin
      if (st == HOLD) begin
        apply_en  = 1'b1;
        apply_tgt = pend_q;
      end else begin
        apply_en  = bus.taken_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= RUN;
      pc_q   <= RESET_PC;
      pend_q <= '0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (apply_en) begin
        if (apply_tgt[1:0] == 2'b00) begin
          pc_q <= apply_tgt;
        end else begin
          pc_q  <= TRAP_VEC;
          mis_q <= 1'b1;
        end
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        st <= RUN;
      end else if (st == RUN) begin
        if (!bus.stall_i) begin
          pc_q <= bus.pc_plus4_o;
        end else if (bus.taken_o) begin
          pend_q <= bus.target_o;
          st     <= HOLD;
        end
      end
    end
  end
endmodule
